// File: rtl/bus_regfile_if.sv
// rtl/bus_regfile_if.sv - shared-bus register file port bundle
interface bus_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              cs;
  logic              r_nw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic [DATA_W-1:0] bus_oe;
  logic              ack;
  logic              err;
  logic [ADDR_W-1:0] mon_sel;
  logic [DATA_W-1:0] mon_q;

  modport master (
    output cs, r_nw, addr, bus_in, mon_sel,
    input  bus_out, bus_oe, ack, err, mon_q
  );

  modport slave (
    input  cs, r_nw, addr, bus_in, mon_sel,
    output bus_out, bus_oe, ack, err, mon_q
  );
endinterface

// File: rtl/bus_regfile.sv
// rtl/bus_regfile.sv - bus-attached register bank with read turnaround and write protect
module bus_regfile #(
  parameter int                       DATA_W     = 8,
  parameter int                       ADDR_W     = 2,
  parameter int                       TURNAROUND = 1,
  parameter logic [DATA_W-1:0]        RESET_VAL  = '0,
  parameter logic [(2**ADDR_W)-1:0]   WP_MASK    = '0
) (
  input logic          clk,
  input logic          rst_n,
  bus_regfile_if.slave bus
);
  localparam int         DEPTH     = 2**ADDR_W;
  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WACK  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_DRIVE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en;
  logic              driving;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cs) begin
          addr_d = bus.addr;
          dir_d  = bus.r_nw;
          if (!bus.r_nw) begin
            wr_en   = ~WP_MASK[bus.addr];
            state_d = S_WACK;
          end else if (TURNAROUND == 0) begin
            state_d = S_DRIVE;
          end else begin
            cnt_d   = TURN_LOAD;
            state_d = S_TURN;
          end
        end
      end
      S_WACK:  state_d = bus.cs ? S_HOLD : S_IDLE;
      S_HOLD:  if (!bus.cs) state_d = S_IDLE;
      S_TURN: begin
        // Dropping cs abandons the read before any data or ack appears.
        cnt_d = cnt_q - 4'd1;
        if (!bus.cs) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: if (!bus.cs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[bus.addr] = bus.bus_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  // Bus enables come from registered state only, so the pins never glitch on cs.
  assign driving     = (state_q == S_DRIVE);
  assign bus.bus_oe  = {DATA_W{driving}};
  assign bus.bus_out = driving ? regs_q[addr_q] : '0;
  assign bus.ack     = driving || (state_q == S_WACK);
  assign bus.err     = (state_q == S_WACK) && !dir_q && WP_MASK[addr_q];
  assign bus.mon_q   = regs_q[bus.mon_sel];
endmodule

// File: tb/tb_bus_regfile.sv
// tb/tb_bus_regfile.sv - table, directed and randomized checks of bus_regfile
module tb_bus_regfile;
  localparam int         DW = 8;
  localparam int         AW = 2;
  localparam logic [3:0] WP = 4'b1000;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          cs      = 1'b0;
  logic          r_nw    = 1'b0;
  logic [AW-1:0] addr    = '0;
  logic [AW-1:0] mon_sel = '0;
  logic [DW-1:0] bus_in  = '0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] oe_w  [3];
  logic [DW-1:0] out_w [3];
  logic          ack_w [3];
  logic          err_w [3];
  logic [DW-1:0] mon_w [3];

  always #5 clk = ~clk;

  // Instance 0: TURNAROUND=0, 1: TURNAROUND=1, 2: TURNAROUND=3; all share stimulus.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();
    assign bif.cs      = cs;
    assign bif.r_nw    = r_nw;
    assign bif.addr    = addr;
    assign bif.bus_in  = bus_in;
    assign bif.mon_sel = mon_sel;
    assign oe_w[g]     = bif.bus_oe;
    assign out_w[g]    = bif.bus_out;
    assign ack_w[g]    = bif.ack;
    assign err_w[g]    = bif.err;
    assign mon_w[g]    = bif.mon_q;
    bus_regfile #(
      .DATA_W(DW), .ADDR_W(AW), .TURNAROUND(g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .RESET_VAL(8'h00), .WP_MASK(WP)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bif)
    );
  end

  typedef struct {
    logic          cs;
    logic          r_nw;
    logic [AW-1:0] addr;
    logic [DW-1:0] bus_in;
    logic [AW-1:0] mon_sel;
    logic [DW-1:0] e_oe;
    logic [DW-1:0] e_out;
    logic          e_ack;
    logic          e_err;
    logic [DW-1:0] e_mon;
  } vec_t;

  vec_t          vt [17];
  logic [DW-1:0] mem [4];
  logic          t_rd;
  logic [AW-1:0] t_a;
  logic [DW-1:0] t_d;
  logic [DW-1:0] t_val;
  int            t_h;
  int            t_gap;
  logic          drv;

  function automatic int ta_of(input int n);
    return (n == 0) ? 0 : ((n == 1) ? 1 : 3);
  endfunction

  function automatic logic [17:0] act_bus(input int n);
    return {oe_w[n], out_w[n], ack_w[n], err_w[n]};
  endfunction

  function automatic logic [17:0] exp_bus(input logic d, input logic [DW-1:0] v,
                                          input logic a, input logic e);
    return {(d ? 8'hFF : 8'h00), (d ? v : 8'h00), a, e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //           cs    r_nw  addr  bus_in ms    oe     out    ack   err   mon
    vt[0]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 1'b0, 2'd2, 8'hA5, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5};
    vt[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 1'b1, 2'd2, 8'h00, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5};
    vt[8]  = '{1'b1, 1'b0, 2'd0, 8'h5A, 2'd2, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'hA5};
    vt[9]  = '{1'b1, 1'b0, 2'd1, 8'hFF, 2'd0, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h00};
    vt[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[11] = '{1'b1, 1'b0, 2'd3, 8'h3C, 2'd3, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00};
    vt[12] = '{1'b1, 1'b1, 2'd0, 8'h00, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[14] = '{1'b1, 1'b0, 2'd1, 8'h3C, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3C};
    vt[15] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5};
    vt[16] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};

    #1;
    for (int n = 0; n < 3; n++) chk($sformatf("reset_bus_i%0d", n), act_bus(n), 18'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors against the TURNAROUND=1 instance.
    for (int i = 0; i < 17; i++) begin
      cs = vt[i].cs; r_nw = vt[i].r_nw; addr = vt[i].addr;
      bus_in = vt[i].bus_in; mon_sel = vt[i].mon_sel;
      @(negedge clk);
      chk($sformatf("vec%0d_bus", i), act_bus(1),
          {vt[i].e_oe, vt[i].e_out, vt[i].e_ack, vt[i].e_err});
      chk($sformatf("vec%0d_mon", i), mon_w[1], vt[i].e_mon);
    end

    // Read latency for all three turnaround settings; later addr/r_nw noise is ignored.
    for (int k = 1; k <= 5; k++) begin
      cs = 1'b1;
      r_nw = (k == 1) ? 1'b1 : 1'($urandom);
      addr = (k == 1) ? 2'd2 : 2'($urandom);
      bus_in = 8'($urandom);
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        drv = (k > ta_of(n));
        chk($sformatf("lat_k%0d_i%0d", k, n), act_bus(n), exp_bus(drv, 8'hA5, drv, 1'b0));
      end
    end
    cs = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 3; n++) chk($sformatf("lat_release_i%0d", n), act_bus(n), 18'h0);

    // cs dropped after two edges: aborts TURNAROUND=3 inside its turnaround.
    for (int k = 1; k <= 4; k++) begin
      cs = (k <= 2);
      r_nw = (k == 1) ? 1'b1 : 1'($urandom);
      addr = (k == 1) ? 2'd2 : 2'($urandom);
      bus_in = 8'($urandom);
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        drv = (k <= 2) && (k > ta_of(n));
        chk($sformatf("abort_k%0d_i%0d", k, n), act_bus(n), exp_bus(drv, 8'hA5, drv, 1'b0));
      end
    end
    cs = 1'b1; r_nw = 1'b0; addr = 2'd0; bus_in = 8'h77; mon_sel = 2'd0;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("post_abort_wr_i%0d", n), act_bus(n), exp_bus(1'b0, 8'h00, 1'b1, 1'b0));
      chk($sformatf("post_abort_mon_i%0d", n), mon_w[n], 8'h77);
    end
    cs = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 3; n++) chk($sformatf("post_abort_idle_i%0d", n), act_bus(n), 18'h0);

    // Asynchronous reset while reading.
    cs = 1'b1; r_nw = 1'b1; addr = 2'd2;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_drive", act_bus(1), exp_bus(1'b1, 8'hA5, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) chk($sformatf("rst_mid_bus_i%0d", n), act_bus(n), 18'h0);
    for (int m = 0; m < 4; m++) begin
      mon_sel = 2'(m);
      #1;
      for (int n = 0; n < 3; n++) chk($sformatf("rst_mid_mon%0d_i%0d", m, n), mon_w[n], 8'h00);
    end
    cs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized transactions against a transaction-level reference model.
    for (int m = 0; m < 4; m++) mem[m] = 8'h00;
    for (int t = 0; t < 60; t++) begin
      t_rd  = 1'($urandom_range(0, 1));
      t_a   = 2'($urandom);
      t_d   = 8'($urandom);
      t_h   = $urandom_range(1, 6);
      t_gap = $urandom_range(1, 3);
      t_val = mem[t_a];
      for (int k = 1; k <= t_h + t_gap; k++) begin
        if (k == 1) begin
          cs = 1'b1; r_nw = t_rd; addr = t_a; bus_in = t_d;
          if (!t_rd && !WP[t_a]) mem[t_a] = t_d;
        end else begin
          cs = (k <= t_h); r_nw = 1'($urandom); addr = 2'($urandom); bus_in = 8'($urandom);
        end
        mon_sel = 2'($urandom);
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
          if (t_rd) begin
            drv = (k <= t_h) && (k > ta_of(n));
            chk($sformatf("rnd%0d_k%0d_rd_i%0d", t, k, n), act_bus(n),
                exp_bus(drv, t_val, drv, 1'b0));
          end else begin
            chk($sformatf("rnd%0d_k%0d_wr_i%0d", t, k, n), act_bus(n),
                exp_bus(1'b0, 8'h00, (k == 1), (k == 1) && WP[t_a]));
          end
          chk($sformatf("rnd%0d_k%0d_mon_i%0d", t, k, n), mon_w[n], mem[mon_sel]);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_regfile.md
Name: bus_regfile

Overview:
Parametrised bank of 2**ADDR_W bus-attached registers sharing one bidirectional data bus, with a single R/W* control, chip select and handshake.
- A transaction-level FSM latches address and direction at select.
- Reads insert a programmable bus-turnaround gap before driving; writes return a one-cycle acknowledge.
- Per-register write protection and a monitor output for a dedicated output pin group.

Parameters:
- DATA_W, 8, data bus and register width
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
- TURNAROUND, 1, read turnaround cycles with bus released (0..15)
- RESET_VAL, 0, reset value of every register (DATA_W bits)
- WP_MASK, 0, DEPTH-bit mask; bit i=1 makes register i write-protected

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cs  in  1  chip select; transaction request, held high for its duration
- r_nw  in  1  1 = READ, 0 = WRITE; sampled only at accept
- addr  in  ADDR_W  register address; sampled only at accept
- bus_in  in  DATA_W  shared bus into block
- bus_out  out  DATA_W  shared bus from block
- bus_oe  out  DATA_W  per-bit output enable (1 = drive, 0 = Z)
- ack  out  1  transaction acknowledge
- err  out  1  write-protect violation flag, valid with ack
- mon_sel  in  ADDR_W  monitor register select
- mon_q  out  DATA_W  combinational reg[mon_sel]

Behaviour:
- States: IDLE, WACK, HOLD, TURN, DRIVE.
- Reset (async, immediate):
  - state = IDLE
  - all registers = RESET_VAL
  - bus_oe = 0, bus_out = 0, ack = 0, err = 0
  - latched addr/dir and turnaround counter = 0
- IDLE: bus_oe = 0, ack = 0, err = 0. On an edge with cs = 1, latch addr and r_nw (accept edge).
  - Write accept:
    - If WP_MASK[addr] = 0, write reg[addr] <= bus_in on the same edge.
    - If WP_MASK[addr] = 1, the register is unchanged.
    - Go to WACK.
  - Read accept:
    - TURNAROUND = 0: go to DRIVE.
    - Otherwise: load counter = TURNAROUND and go to TURN.
- WACK: ack = 1 for exactly one cycle; err = 1 if the latched address is protected. Next: HOLD if cs = 1, else IDLE.
- HOLD: ack = 0. Wait for cs = 0, then IDLE. A new write needs cs low for at least one edge.
- TURN:
  - bus_oe = 0, ack = 0.
  - Counter decrements each edge; leave for DRIVE on the edge where counter = 1.
  - Gives exactly TURNAROUND cycles with the bus released.
  - cs = 0 during TURN aborts to IDLE; no ack is issued.
- DRIVE:
  - bus_oe = all ones, bus_out = reg[latched addr], ack = 1.
  - Stays while cs = 1. Edge with cs = 0 returns to IDLE, so bus_oe falls one cycle after cs falls.
- bus_out = 0 in every state except DRIVE.
- bus_oe is decoded from registered state only, never combinationally from cs or r_nw.
- Latency: read data valid on bus TURNAROUND+1 cycles after the accept edge; write ack 1 cycle after the accept edge.
- Mid-transaction changes to addr, r_nw or bus_in are ignored.
  - A register written in an earlier transaction is visible on the next read.
  - DRIVE reflects current register contents, combinationally indexed by the latched address.
- mon_q updates the cycle after a write edge. mon_sel is fully combinational and independent of the FSM.
- Out-of-range addresses cannot occur, since DEPTH = 2**ADDR_W.
- Reset asserted mid-transaction (any state) forces IDLE and releases the bus immediately; no ack follows.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release, cs = 0 -> bus_oe = 0x00, ack = 0, mon_q = 0x00 for all mon_sel.
- Write: cs = 1, r_nw = 0, addr = 2, bus_in = 0xA5 for 1 cycle -> ack = 1, err = 0 next cycle; mon_sel = 2 gives mon_q = 0xA5; regs 0/1/3 stay 0x00.
- Read (TURNAROUND = 1): after the write, cs = 1, r_nw = 1, addr = 2 held -> cycle 1 bus_oe = 0x00, cycle 2 onward bus_oe = 0xFF, bus_out = 0xA5, ack = 1.
  - cs low -> bus_oe = 0x00 one cycle later.
  - Repeat with TURNAROUND = 0 (data on cycle 1) and TURNAROUND = 3 (data on cycle 4).
- Write protect (WP_MASK = 4'b1000): write 0x3C to addr 3 -> ack = 1, err = 1, reg[3] stays 0x00; write to addr 1 -> err = 0, reg[1] = 0x3C.
- Latch stability: in DRIVE on addr 2, change addr to 0 and r_nw to 0 with cs still high -> bus_out stays 0xA5, no register modified.
- Reset mid-read and abort:
  - rst_n low during DRIVE -> bus_oe = 0x00 the same cycle, all regs = 0x00.
  - cs dropped during TURN -> return to IDLE, bus never driven, ack never asserted.
